busca_instrucao: RTL and testbench
==================================

# busca_instrucao

Instruction-fetch stage of the 16-bit pipeline, directly upstream of the ID/RF stage. It owns the program counter, runs a req/ack handshake with instruction memory, and presents one instruction plus its PC per cycle to decode. It absorbs decode stalls with a one-entry reserve buffer and redirects on branches/jumps signalled from execute, discarding any in-flight fetch.

## Interface
- LARG, 16: instruction and PC width.
- PC_RESET, 16'h0000: first fetch address after reset.

Ports:
- clock  in  1  rising-edge clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  fetch request to instruction memory.
- mem_addr  out  LARG  word address of the request.
- mem_ack  in  1  memory completion; mem_dado valid in the same cycle.
- mem_dado  in  LARG  fetched instruction.
- stall  in  1  decode cannot accept this cycle.
- desvio  in  1  one-cycle redirect pulse from execute.
- desvio_alvo  in  LARG  redirect target, valid with desvio.
- instrucao  out  LARG  instruction to decode.
- pc_saida  out  LARG  address of instrucao.
- valido  out  1  instrucao/pc_saida hold a live instruction.

## Operation
- Reset values: state INICIO, pc=PC_RESET, mem_req=0, mem_addr=PC_RESET, instrucao=16'h0000 (NOP), pc_saida=0, valido=0, reserve empty.
- Output is "livre" when !valido || !stall. An output is consumed on a rising edge where valido && !stall.
- Handshake: once mem_req=1, mem_addr stays stable until mem_ack is sampled high. mem_ack without mem_req is ignored. A new request may start in the cycle after an ack.
- States:
  - INICIO: mem_req=0; next state BUSCA.
  - BUSCA: mem_req=1, mem_addr=pc. On ack with output livre: instrucao<=mem_dado, pc_saida<=pc, valido<=1, pc<=pc+1, stay in BUSCA. On ack with output not livre: the reserve takes {mem_dado, pc}, pc<=pc+1, go to CHEIO. With no ack and output livre: valido<=0.
  - CHEIO: mem_req=0. When stall=0, the reserve moves to the output, valido=1, reserve is emptied, go to BUSCA.
  - DESCARTE: mem_req=1 at the old address. On ack: data is dropped, pc<=alvo_pendente, go to BUSCA.
- desvio has highest priority in every state:
  - valido<=0 and the reserve is emptied, even if stall=1.
  - In BUSCA without ack: alvo_pendente<=desvio_alvo, go to DESCARTE.
  - In BUSCA with ack in the same cycle: data is dropped, pc<=desvio_alvo, stay in BUSCA.
  - In INICIO or CHEIO: pc<=desvio_alvo, go to BUSCA.
  - In DESCARTE: alvo_pendente is overwritten with the newest target. If ack arrives in the same cycle, pc<=desvio_alvo and go to BUSCA.
- PC arithmetic is modulo 2^LARG, word-addressed: 16'hFFFF+1 = 16'h0000.
- Reset mid-request: all state returns to reset values immediately. Any ack arriving during or after reset for the abandoned request is ignored, because mem_req=0 in INICIO.

## Timing
- All registers update on the rising edge of clock. ID/RF samples on the falling edge, giving half a cycle for decode paths.
- Zero-wait memory (ack in the request cycle): with reset released before edge 0, INICIO is cycle 0 and the request for PC_RESET is in cycle 1. The instruction appears on the outputs in cycle 2, and throughput is one instruction per cycle.
- N wait cycles add N cycles of latency. valido is low during the gap.
- Redirect penalty with zero-wait memory: valido=0 in the cycle after desvio; the target address is requested in that same cycle. A redirect during an outstanding request adds the remaining wait of that request.
- When stall is released, the reserve reaches the output on the next edge. The following fetch is issued in the same cycle as that transfer.

## Structure
- Shared package: state enum {INICIO, BUSCA, CHEIO, DESCARTE}, the NOP constant 16'h0000, and LARG.
- Sub-module reserva_instrucao: a one-entry {instrucao, pc, cheio} register with load, unload and flush inputs.
- The top level holds the FSM, pc, alvo_pendente and the output register.

## Test plan
- Reset release, ack tied high, memory returns the address as data -> instrucao 0000, 0001, 0002 on consecutive cycles starting cycle 2, with pc_saida equal to instrucao.
- Ack delayed 3 cycles -> mem_addr stable and mem_req high for 4 cycles, valido low for 3 cycles, then one valid instruction.
- stall high for 4 cycles during streaming -> output frozen, reserve filled, mem_req=0; on release, the next two instructions appear back-to-back with no loss or duplication.
- desvio to 16'h0040 while stall=1 and the reserve is full -> valido=0 next cycle, then instruction 0040 is next at the output.
- desvio to 16'h0080 during a 2-wait request to 0005 -> the 0005 data is dropped, the next request goes to 0080, and a second desvio to 00A0 before the ack wins.
- pc at 16'hFFFF with zero wait -> next fetch address 16'h0000. Asserting reset_n low mid-request -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM states,
// the NOP encoding and the default datapath width.
package busca_instrucao_pkg;

  localparam int LARG = 16;

  localparam logic [15:0] NOP = 16'h0000;

  typedef enum logic [1:0] {
    INICIO   = 2'd0,
    BUSCA    = 2'd1,
    CHEIO    = 2'd2,
    DESCARTE = 2'd3
  } estado_t;

endpackage

// File: rtl/busca_instrucao_reserva.sv
// One-entry reserve holding a fetched {instruction, pc} while decode stalls.
// Flush wins over load so a redirect can never leave stale work behind.
module reserva_instrucao
  import busca_instrucao_pkg::*;
#(
  parameter int LARG = busca_instrucao_pkg::LARG
) (
  input  logic            clock_i,
  input  logic            reset_n_i,
  input  logic            carga_i,
  input  logic            descarga_i,
  input  logic            limpa_i,
  input  logic [LARG-1:0] instr_i,
  input  logic [LARG-1:0] pc_i,
  output logic [LARG-1:0] instr_o,
  output logic [LARG-1:0] pc_o,
  output logic            cheio_o
);

  logic            cheio_q;
  logic [LARG-1:0] instr_q;
  logic [LARG-1:0] pc_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cheio_q <= 1'b0;
    end else if (limpa_i) begin
      cheio_q <= 1'b0;
    end else if (carga_i) begin
      cheio_q <= 1'b1;
    end else if (descarga_i) begin
      cheio_q <= 1'b0;
    end
  end

  // Payload is qualified by cheio_q, so it needs no reset.
  always_ff @(posedge clock_i) begin
    if (carga_i && !limpa_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign cheio_o = cheio_q;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake with
// instruction memory and hands one {instruction, pc} per cycle to decode.
module busca_instrucao
  import busca_instrucao_pkg::*;
#(
  parameter int              LARG     = busca_instrucao_pkg::LARG,
  parameter logic [LARG-1:0] PC_RESET = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            mem_req,
  output logic [LARG-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [LARG-1:0] mem_dado,
  input  logic            stall,
  input  logic            desvio,
  input  logic [LARG-1:0] desvio_alvo,
  output logic [LARG-1:0] instrucao,
  output logic [LARG-1:0] pc_saida,
  output logic            valido
);

  estado_t         estado_q, estado_d;
  logic [LARG-1:0] pc_q, pc_d;
  logic [LARG-1:0] alvo_q, alvo_d;
  logic [LARG-1:0] instr_q, instr_d;
  logic [LARG-1:0] pcs_q, pcs_d;
  logic            valido_q, valido_d;

  logic            res_carga, res_descarga, res_limpa;
  logic [LARG-1:0] res_instr, res_pc;
  logic            res_cheio;
  logic            livre;

  reserva_instrucao #(.LARG(LARG)) u_reserva (
    .clock_i    (clock),
    .reset_n_i  (reset_n),
    .carga_i    (res_carga),
    .descarga_i (res_descarga),
    .limpa_i    (res_limpa),
    .instr_i    (mem_dado),
    .pc_i       (pc_q),
    .instr_o    (res_instr),
    .pc_o       (res_pc),
    .cheio_o    (res_cheio)
  );

  assign livre = !valido_q || !stall;

  always_comb begin
    estado_d     = estado_q;
    pc_d         = pc_q;
    alvo_d       = alvo_q;
    instr_d      = instr_q;
    pcs_d        = pcs_q;
    valido_d     = valido_q;
    res_carga    = 1'b0;
    res_descarga = 1'b0;
    res_limpa    = 1'b0;

    case (estado_q)
      INICIO: begin
        estado_d = BUSCA;
        if (desvio) begin
          pc_d      = desvio_alvo;
          valido_d  = 1'b0;
          res_limpa = 1'b1;
        end
      end

      BUSCA: begin
        if (desvio) begin
          valido_d  = 1'b0;
          res_limpa = 1'b1;
          if (mem_ack) begin
            pc_d = desvio_alvo;
          end else begin
            alvo_d   = desvio_alvo;
            estado_d = DESCARTE;
          end
        end else if (mem_ack) begin
          pc_d = pc_q + LARG'(1);
          if (livre) begin
            instr_d  = mem_dado;
            pcs_d    = pc_q;
            valido_d = 1'b1;
          end else begin
            res_carga = 1'b1;
            estado_d  = CHEIO;
          end
        end else if (livre) begin
          valido_d = 1'b0;
        end
      end

      CHEIO: begin
        if (desvio) begin
          valido_d  = 1'b0;
          res_limpa = 1'b1;
          pc_d      = desvio_alvo;
          estado_d  = BUSCA;
        end else if (!stall) begin
          // Output is consumed this edge; the reserve refills it directly.
          estado_d     = BUSCA;
          res_descarga = 1'b1;
          instr_d      = res_instr;
          pcs_d        = res_pc;
          valido_d     = res_cheio;
        end
      end

      DESCARTE: begin
        // The outstanding request must still complete; its data is dropped.
        if (desvio) begin
          alvo_d    = desvio_alvo;
          valido_d  = 1'b0;
          res_limpa = 1'b1;
          if (mem_ack) begin
            pc_d     = desvio_alvo;
            estado_d = BUSCA;
          end
        end else if (mem_ack) begin
          pc_d     = alvo_q;
          estado_d = BUSCA;
        end
      end

      default: estado_d = INICIO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= INICIO;
      pc_q     <= PC_RESET;
      alvo_q   <= PC_RESET;
      instr_q  <= LARG'(NOP);
      pcs_q    <= '0;
      valido_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      alvo_q   <= alvo_d;
      instr_q  <= instr_d;
      pcs_q    <= pcs_d;
      valido_q <= valido_d;
    end
  end

  assign mem_req   = (estado_q == BUSCA) || (estado_q == DESCARTE);
  assign mem_addr  = pc_q;
  assign instrucao = instr_q;
  assign pc_saida  = pcs_q;
  assign valido    = valido_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_busca_instrucao;

  localparam int          LARG     = 16;
  localparam logic [15:0] PC_RESET = 16'h0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_dado = 16'h0;
  logic        stall = 1'b0;
  logic        desvio = 1'b0;
  logic [15:0] desvio_alvo = 16'h0;
  logic [15:0] instrucao;
  logic [15:0] pc_saida;
  logic        valido;

  int vetores = 0;
  int erros   = 0;

  always #5 clock = ~clock;

  busca_instrucao #(.LARG(LARG), .PC_RESET(PC_RESET)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_dado    (mem_dado),
    .stall       (stall),
    .desvio      (desvio),
    .desvio_alvo (desvio_alvo),
    .instrucao   (instrucao),
    .pc_saida    (pc_saida),
    .valido      (valido)
  );

  // Reference model: started flag, discard flag, reserve as a queue,
  // and the decode-side output register.
  bit          m_ini = 1'b0;
  bit          m_drop = 1'b0;
  logic [15:0] m_tgt = 16'h0;
  logic [15:0] m_pc = PC_RESET;
  logic [15:0] m_res_i[$];
  logic [15:0] m_res_p[$];
  bit          m_v = 1'b0;
  logic [15:0] m_instr = 16'h0;
  logic [15:0] m_pco = 16'h0;
  bit          m_livre;
  bit          e_req;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_ini = 1'b0; m_drop = 1'b0; m_tgt = 16'h0; m_pc = PC_RESET;
      m_res_i.delete(); m_res_p.delete();
      m_v = 1'b0; m_instr = 16'h0; m_pco = 16'h0;
    end else if (!m_ini) begin
      m_ini = 1'b1;
      if (desvio) m_pc = desvio_alvo;
    end else if (m_res_i.size() != 0) begin
      if (desvio) begin
        m_res_i.delete(); m_res_p.delete();
        m_v = 1'b0; m_pc = desvio_alvo;
      end else if (!stall) begin
        m_instr = m_res_i.pop_front();
        m_pco   = m_res_p.pop_front();
        m_v     = 1'b1;
      end
    end else begin
      m_livre = !m_v || !stall;
      if (desvio) begin
        m_v = 1'b0;
        if (mem_ack) begin m_pc = desvio_alvo; m_drop = 1'b0; end
        else begin m_drop = 1'b1; m_tgt = desvio_alvo; end
      end else if (m_drop) begin
        if (mem_ack) begin m_pc = m_tgt; m_drop = 1'b0; end
      end else if (mem_ack) begin
        if (m_livre) begin
          m_instr = mem_dado; m_pco = m_pc; m_v = 1'b1;
        end else begin
          m_res_i.push_back(mem_dado); m_res_p.push_back(m_pc);
        end
        m_pc = m_pc + 16'd1;
      end else if (m_livre) begin
        m_v = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    e_req = m_ini && (m_res_i.size() == 0);
    vetores++;
    if (mem_req !== e_req || mem_addr !== m_pc || valido !== m_v ||
        ((m_v || !m_ini) && (instrucao !== m_instr || pc_saida !== m_pco))) begin
      erros++;
      $display("FAIL ciclo t=%0t: req=%b addr=%h v=%b instr=%h pc=%h, expected req=%b addr=%h v=%b instr=%h pc=%h",
               $time, mem_req, mem_addr, valido, instrucao, pc_saida,
               e_req, m_pc, m_v, m_instr, m_pco);
    end
  end

  task automatic chk(input string nome, input logic [15:0] got, input logic [15:0] exp);
    vetores++;
    if (got !== exp) begin
      erros++;
      $display("FAIL %s: got %h expected %h", nome, got, exp);
    end
  endtask

  task automatic tick(input logic ack, input logic st, input logic dsv, input logic [15:0] alvo);
    @(negedge clock);
    mem_ack = ack; stall = st; desvio = dsv; desvio_alvo = alvo;
    mem_dado = mem_addr;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    // Cycle 0: reset released, INICIO.
    @(negedge clock);
    reset_n = 1'b1; mem_ack = 1'b1; mem_dado = mem_addr;
    chk("c0_req", {15'd0, mem_req}, 16'h0);
    chk("c0_addr", mem_addr, 16'h0000);
    chk("c0_valido", {15'd0, valido}, 16'h0);
    chk("c0_instr", instrucao, 16'h0000);

    tick(1, 0, 0, 0);                     // cycle 1
    chk("c1_req", {15'd0, mem_req}, 16'h1);
    chk("c1_addr", mem_addr, 16'h0000);
    tick(1, 0, 0, 0);                     // cycle 2
    chk("c2_instr", instrucao, 16'h0000);
    chk("c2_valido", {15'd0, valido}, 16'h1);
    tick(1, 0, 0, 0);                     // cycle 3
    chk("c3_instr", instrucao, 16'h0001);
    chk("c3_pc", pc_saida, 16'h0001);
    tick(0, 0, 0, 0);                     // cycle 4: start 3-wait request to 0003
    chk("c4_instr", instrucao, 16'h0002);
    tick(0, 0, 0, 0);                     // cycle 5
    chk("w5_valido", {15'd0, valido}, 16'h0);
    chk("w5_addr", mem_addr, 16'h0003);
    tick(0, 0, 0, 0);                     // cycle 6
    chk("w6_req", {15'd0, mem_req}, 16'h1);
    tick(1, 0, 0, 0);                     // cycle 7: ack
    chk("w7_addr", mem_addr, 16'h0003);
    chk("w7_valido", {15'd0, valido}, 16'h0);
    tick(1, 1, 0, 0);                     // cycle 8: stall begins
    chk("w8_instr", instrucao, 16'h0003);
    chk("w8_valido", {15'd0, valido}, 16'h1);
    tick(1, 1, 0, 0);                     // cycle 9
    chk("s9_req", {15'd0, mem_req}, 16'h0);
    chk("s9_instr", instrucao, 16'h0003);
    tick(1, 1, 0, 0);                     // cycle 10
    tick(1, 1, 0, 0);                     // cycle 11
    chk("s11_instr", instrucao, 16'h0003);
    tick(1, 0, 0, 0);                     // cycle 12: release
    tick(1, 0, 0, 0);                     // cycle 13
    chk("s13_instr", instrucao, 16'h0004);
    chk("s13_addr", mem_addr, 16'h0005);
    tick(1, 1, 0, 0);                     // cycle 14: fill reserve with 0006
    chk("s14_instr", instrucao, 16'h0005);
    tick(1, 1, 1, 16'h0040);              // cycle 15: redirect with reserve full
    chk("d15_req", {15'd0, mem_req}, 16'h0);
    tick(1, 0, 0, 0);                     // cycle 16
    chk("d16_valido", {15'd0, valido}, 16'h0);
    chk("d16_addr", mem_addr, 16'h0040);
    tick(1, 0, 1, 16'h0005);              // cycle 17
    chk("d17_instr", instrucao, 16'h0040);
    chk("d17_pc", pc_saida, 16'h0040);
    tick(0, 0, 1, 16'h0080);              // cycle 18: request 0005, redirect
    chk("d18_addr", mem_addr, 16'h0005);
    tick(0, 0, 1, 16'h00A0);              // cycle 19: newer redirect
    chk("d19_addr", mem_addr, 16'h0005);
    chk("d19_req", {15'd0, mem_req}, 16'h1);
    tick(1, 0, 0, 0);                     // cycle 20: ack for dropped 0005
    chk("d20_addr", mem_addr, 16'h0005);
    tick(1, 0, 0, 0);                     // cycle 21
    chk("d21_addr", mem_addr, 16'h00A0);
    chk("d21_valido", {15'd0, valido}, 16'h0);
    tick(1, 0, 1, 16'hFFFF);              // cycle 22
    chk("d22_pc", pc_saida, 16'h00A0);
    tick(1, 0, 0, 0);                     // cycle 23
    chk("f23_addr", mem_addr, 16'hFFFF);
    tick(0, 0, 0, 0);                     // cycle 24
    chk("f24_pc", pc_saida, 16'hFFFF);
    chk("f24_addr", mem_addr, 16'h0000);
    chk("f24_req", {15'd0, mem_req}, 16'h1);

    #2 reset_n = 1'b0;
    #1;
    chk("rst_req", {15'd0, mem_req}, 16'h0);
    chk("rst_valido", {15'd0, valido}, 16'h0);
    chk("rst_instr", instrucao, 16'h0000);
    chk("rst_pc", pc_saida, 16'h0000);
    chk("rst_addr", mem_addr, PC_RESET);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    chk("rel_req", {15'd0, mem_req}, 16'h0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (i % 1000 == 500) reset_n = 1'b0;
      else reset_n = 1'b1;
      mem_ack     = ($urandom_range(0, 99) < 55);
      stall       = ($urandom_range(0, 99) < 30);
      desvio      = ($urandom_range(0, 99) < 5);
      desvio_alvo = 16'($urandom);
      mem_dado    = 16'($urandom);
    end
    @(negedge clock);
    mem_ack = 1'b0; stall = 1'b0; desvio = 1'b0;
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule
